// File: rtl/memory_package.sv
// Shared types and default widths for the 8x8 memory initiator.
package memory_package;

    localparam int unsigned MEM_ADDR_W = 3;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        WRITE,
        READ,
        RESP
    } mem_init_state_e;

endpackage

// File: rtl/mem_8x8_initiator.sv
// Initiator for the 8x8 memory: valid/ready requests in, registered memory pins out.
// Optional post-reset memory clear is enabled by defining MEM_INIT_CLEAR_EN.
module mem_8x8_initiator
    import memory_package::*;
#(
    parameter int unsigned ADDR_W       = MEM_ADDR_W,
    parameter int unsigned DATA_W       = MEM_DATA_W,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

`ifdef MEM_INIT_CLEAR_EN
    localparam int unsigned CLR_W = ADDR_W + 1;
    localparam mem_init_state_e RESET_STATE = CLEAR;
    logic [CLR_W-1:0] clr_cnt, clr_cnt_n;
`else
    localparam mem_init_state_e RESET_STATE = IDLE;
`endif

    mem_init_state_e   state, state_n;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_n;
    logic              req_ready_n, rsp_valid_n, mem_we_n, busy_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_data_in_n, rsp_rdata_n;
    logic              accept;
    logic              lat_done;

    assign accept   = req_valid && req_ready;
    // Address is launched on the accept edge; data_out settles READ_LATENCY
    // edges later and is captured on the edge after that.
    assign lat_done = (lat_cnt == LAT_W'(READ_LATENCY));

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= RESET_STATE;
            lat_cnt          <= '0;
            req_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_data_in      <= '0;
            busy             <= 1'b0;
`ifdef MEM_INIT_CLEAR_EN
            clr_cnt          <= '0;
`endif
        end else begin
            state            <= state_n;
            lat_cnt          <= lat_cnt_n;
            req_ready        <= req_ready_n;
            rsp_valid        <= rsp_valid_n;
            rsp_rdata        <= rsp_rdata_n;
            mem_write_enable <= mem_we_n;
            mem_addr         <= mem_addr_n;
            mem_data_in      <= mem_data_in_n;
            busy             <= busy_n;
`ifdef MEM_INIT_CLEAR_EN
            clr_cnt          <= clr_cnt_n;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
`ifdef MEM_INIT_CLEAR_EN
            CLEAR: if (clr_cnt == CLR_W'(DEPTH)) state_n = IDLE;
`else
            CLEAR: state_n = IDLE;
`endif
            IDLE:  if (accept) state_n = req_write ? WRITE : READ;
            WRITE: state_n = IDLE;
            READ:  if (lat_done) state_n = RESP;
            RESP:  if (rsp_valid && rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs, aligned with the next state.
    always_comb begin
        req_ready_n   = (state_n == IDLE);
        busy_n        = (state_n != IDLE);
        rsp_valid_n   = (state_n == RESP);
        mem_we_n      = 1'b0;
        mem_addr_n    = mem_addr;
        mem_data_in_n = mem_data_in;
        rsp_rdata_n   = rsp_rdata;
        lat_cnt_n     = lat_cnt;
`ifdef MEM_INIT_CLEAR_EN
        clr_cnt_n     = clr_cnt;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    mem_addr_n = req_addr;
                    lat_cnt_n  = '0;
                    if (req_write) begin
                        mem_we_n      = 1'b1;
                        mem_data_in_n = req_wdata;
                    end
                end
            end
            READ: begin
                if (lat_done) rsp_rdata_n = mem_data_out;
                else          lat_cnt_n   = lat_cnt + LAT_W'(1);
            end
`ifdef MEM_INIT_CLEAR_EN
            CLEAR: begin
                if (clr_cnt != CLR_W'(DEPTH)) begin
                    mem_we_n      = 1'b1;
                    mem_addr_n    = clr_cnt[ADDR_W-1:0];
                    mem_data_in_n = '0;
                    clr_cnt_n     = clr_cnt + CLR_W'(1);
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_8x8_initiator.sv
// Bench for mem_8x8_initiator: two instances (READ_LATENCY 1 and 3) share stimulus,
// each with its own behavioural memory; expectations come from a reference array.
module tb_mem_8x8_initiator;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned RL_A   = 1;
    localparam int unsigned RL_B   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_ready;

    logic              req_ready_a, rsp_valid_a, we_a, busy_a;
    logic [DATA_W-1:0] rsp_rdata_a, din_a, dout_a;
    logic [ADDR_W-1:0] addr_a;
    logic              req_ready_b, rsp_valid_b, we_b, busy_b;
    logic [DATA_W-1:0] rsp_rdata_b, din_b, dout_b;
    logic [ADDR_W-1:0] addr_b;

    logic              rdy   [2];
    logic              vld   [2];
    logic              we    [2];
    logic              bsy   [2];
    logic [DATA_W-1:0] rdata [2];
    logic [DATA_W-1:0] din   [2];
    logic [ADDR_W-1:0] maddr [2];

    assign rdy[0]   = req_ready_a;  assign rdy[1]   = req_ready_b;
    assign vld[0]   = rsp_valid_a;  assign vld[1]   = rsp_valid_b;
    assign we[0]    = we_a;         assign we[1]    = we_b;
    assign bsy[0]   = busy_a;       assign bsy[1]   = busy_b;
    assign rdata[0] = rsp_rdata_a;  assign rdata[1] = rsp_rdata_b;
    assign din[0]   = din_a;        assign din[1]   = din_b;
    assign maddr[0] = addr_a;       assign maddr[1] = addr_b;

    int                vectors     = 0;
    int                miscompares = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] last_din;

    always #5 clk = ~clk;

    mem_8x8_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL_A)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
        .mem_write_enable(we_a), .mem_addr(addr_a), .mem_data_in(din_a),
        .mem_data_out(dout_a), .busy(busy_a)
    );

    mem_8x8_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL_B)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
        .mem_write_enable(we_b), .mem_addr(addr_b), .mem_data_in(din_b),
        .mem_data_out(dout_b), .busy(busy_b)
    );

    // Behavioural memories: synchronous write, read data RL clocks after address.
    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [DATA_W-1:0] pipe_b [RL_B];

    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= din_a;
        dout_a <= mem_a[addr_a];
    end

    always @(posedge clk) begin
        if (we_b) mem_b[addr_b] <= din_b;
        pipe_b[0] <= mem_b[addr_b];
        for (int i = 1; i < RL_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign dout_b = pipe_b[RL_B-1];

    function automatic int lat_of(input int d);
        return (d == 0) ? int'(1 + RL_A) : int'(1 + RL_B);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_rdy%0d", tag, d),   32'(rdy[d]),   32'd0);
            chk($sformatf("%s_vld%0d", tag, d),   32'(vld[d]),   32'd0);
            chk($sformatf("%s_rdata%0d", tag, d), 32'(rdata[d]), 32'd0);
            chk($sformatf("%s_we%0d", tag, d),    32'(we[d]),    32'd0);
            chk($sformatf("%s_addr%0d", tag, d),  32'(maddr[d]), 32'd0);
            chk($sformatf("%s_din%0d", tag, d),   32'(din[d]),   32'd0);
            chk($sformatf("%s_busy%0d", tag, d),  32'(bsy[d]),   32'd0);
        end
    endtask

    // Called with reset just released mid-cycle.
    task automatic post_reset();
        last_din = '0;
`ifdef MEM_INIT_CLEAR_EN
        for (int i = 0; i < int'(DEPTH); i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("clr_we%0d_%0d", d, i),   32'(we[d]),    32'd1);
                chk($sformatf("clr_addr%0d_%0d", d, i), 32'(maddr[d]), 32'(i));
                chk($sformatf("clr_din%0d_%0d", d, i),  32'(din[d]),   32'd0);
                chk($sformatf("clr_rdy%0d_%0d", d, i),  32'(rdy[d]),   32'd0);
                chk($sformatf("clr_busy%0d_%0d", d, i), 32'(bsy[d]),   32'd1);
            end
            ref_mem[i] = '0;
        end
`endif
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rel_rdy%0d", d),  32'(rdy[d]), 32'd1);
            chk($sformatf("rel_we%0d", d),   32'(we[d]),  32'd0);
            chk($sformatf("rel_busy%0d", d), 32'(bsy[d]), 32'd0);
            chk($sformatf("rel_vld%0d", d),  32'(vld[d]), 32'd0);
            chk($sformatf("rel_din%0d", d),  32'(din[d]), 32'd0);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = w;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wr_we%0d", d),   32'(we[d]),    32'd1);
            chk($sformatf("wr_addr%0d", d), 32'(maddr[d]), 32'(a));
            chk($sformatf("wr_din%0d", d),  32'(din[d]),   32'(w));
            chk($sformatf("wr_rdy%0d", d),  32'(rdy[d]),   32'd0);
            chk($sformatf("wr_busy%0d", d), 32'(bsy[d]),   32'd1);
        end
        // Request pins change while busy; they must be ignored.
        req_write = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = DATA_W'($urandom);
        tick();
        req_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wr_end_we%0d", d),   32'(we[d]),  32'd0);
            chk($sformatf("wr_end_rdy%0d", d),  32'(rdy[d]), 32'd1);
            chk($sformatf("wr_end_busy%0d", d), 32'(bsy[d]), 32'd0);
            chk($sformatf("wr_end_din%0d", d),  32'(din[d]), 32'(w));
        end
        ref_mem[a] = w;
        last_din   = w;
    endtask

    // early=1: rsp_ready high from the start; otherwise held low for the latency
    // window plus 'hold' extra clocks before the response is taken.
    task automatic do_read(input logic [ADDR_W-1:0] a, input bit early, input int hold);
        logic [DATA_W-1:0] exp_d;
        int                kmax;
        bit                exp_v, exp_r;
        exp_d = ref_mem[a];
        kmax  = early ? lat_of(1) + 1 : lat_of(1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = DATA_W'($urandom);
        rsp_ready = early;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rd_acc_we%0d", d),   32'(we[d]),    32'd0);
            chk($sformatf("rd_acc_addr%0d", d), 32'(maddr[d]), 32'(a));
            chk($sformatf("rd_acc_rdy%0d", d),  32'(rdy[d]),   32'd0);
            chk($sformatf("rd_acc_busy%0d", d), 32'(bsy[d]),   32'd1);
            chk($sformatf("rd_acc_vld%0d", d),  32'(vld[d]),   32'd0);
        end
        req_write = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = DATA_W'($urandom);
        for (int k = 1; k <= kmax; k++) begin
            tick();
            if (early) req_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                exp_v = early ? (k == lat_of(d)) : (k >= lat_of(d));
                exp_r = early && (k > lat_of(d));
                chk($sformatf("rd_vld%0d_k%0d", d, k),  32'(vld[d]), 32'(exp_v));
                chk($sformatf("rd_rdy%0d_k%0d", d, k),  32'(rdy[d]), 32'(exp_r));
                chk($sformatf("rd_busy%0d_k%0d", d, k), 32'(bsy[d]), 32'(!exp_r));
                chk($sformatf("rd_we%0d_k%0d", d, k),   32'(we[d]),  32'd0);
                chk($sformatf("rd_din%0d_k%0d", d, k),  32'(din[d]), 32'(last_din));
                if (exp_v) chk($sformatf("rd_data%0d_k%0d", d, k), 32'(rdata[d]), 32'(exp_d));
            end
        end
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("hold_vld%0d", d),  32'(vld[d]),   32'd1);
                    chk($sformatf("hold_data%0d", d), 32'(rdata[d]), 32'(exp_d));
                    chk($sformatf("hold_rdy%0d", d),  32'(rdy[d]),   32'd0);
                end
            end
            rsp_ready = 1'b1;
            tick();
            req_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rsp_done_vld%0d", d),  32'(vld[d]), 32'd0);
                chk($sformatf("rsp_done_rdy%0d", d),  32'(rdy[d]), 32'd1);
                chk($sformatf("rsp_done_busy%0d", d), 32'(bsy[d]), 32'd0);
            end
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [ADDR_W-1:0] ra;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

        // Asynchronous reset asserted and released mid-cycle.
        #2 reset = 1'b1;
        #1 check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #3 check_all_zero("rst_hold");
        reset = 1'b0;
        post_reset();

`ifdef MEM_INIT_CLEAR_EN
        do_read(3'd7, 1'b1, 0);
`endif

        // Directed write then reads of the same location.
        do_write(3'd3, 8'hA5);
        do_read(3'd3, 1'b1, 0);
        do_read(3'd3, 1'b0, 5);

        // Fill every address, then randomized traffic.
        for (int i = 0; i < int'(DEPTH); i++) do_write(ADDR_W'(i), DATA_W'($urandom));
        for (int n = 0; n < 40; n++) begin
            ra = ADDR_W'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) do_write(ra, DATA_W'($urandom));
            else do_read(ra, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset while a read is in flight: everything drops, no response follows.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1 check_all_zero("rst_read");
        @(posedge clk);
        #1 check_all_zero("rst_read_hold");
        #2 reset = 1'b0;
        post_reset();
        repeat (5) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("no_rsp_vld%0d", d), 32'(vld[d]), 32'd0);
                chk($sformatf("no_rsp_rdy%0d", d), 32'(rdy[d]), 32'd1);
            end
        end
        rsp_ready = 1'b0;
        do_read(3'd5, 1'b1, 0);
        do_write(3'd0, 8'h3C);
        do_read(3'd0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
